// File: rtl/bos_pwr_seq_pkg.sv
// Shared types and constants for the BOS power sequencer: FSM states, register
// indices of the rail-control registers and the values written to them.
package bos_pwr_seq_pkg;

   typedef enum logic [3:0] {
      StOff, StWVcore, StTVcore, StWVdig, StTVdig, StWFunc,
      StOn, StDFunc, StTDfunc, StDVdig, StTDvdig, StDVcore
   } state_e;

   localparam int unsigned NUM_REGS  = 9;
   localparam int unsigned REG_FUNC  = 6;
   localparam int unsigned REG_VCORE = 7;
   localparam int unsigned REG_VDIG  = 8;

   localparam logic [7:0] VAL_CLR = 8'h00;
   localparam logic [7:0] VAL_SET = 8'h01;

   function automatic logic [NUM_REGS-1:0] reg_sel(input int unsigned idx);
      return NUM_REGS'(1) << idx;
   endfunction

endpackage

// File: rtl/bos_pwr_seq_if.sv
// Command, host-write and register-bus signals of bos_pwr_seq.
// Power-good inputs pg_vcore/pg_vdig exist only when BOS_PWR_SEQ_WDT_EN is defined.
interface bos_pwr_seq_if;
   import bos_pwr_seq_pkg::*;

   logic                cmd_valid;
   logic                cmd_on;
   logic                cmd_ready;
   logic [NUM_REGS-1:0] host_valid;
   logic [7:0]          host_data;
   logic                host_ready;
   logic [NUM_REGS-1:0] valid_bus;
   logic [7:0]          master_data;
   logic                busy;
   logic                pwr_on;
   logic                fault;
`ifdef BOS_PWR_SEQ_WDT_EN
   logic                pg_vcore;
   logic                pg_vdig;
`endif

   modport master (
      output cmd_valid, cmd_on, host_valid, host_data,
`ifdef BOS_PWR_SEQ_WDT_EN
      output pg_vcore, pg_vdig,
`endif
      input  cmd_ready, host_ready, valid_bus, master_data, busy, pwr_on, fault
   );

   modport slave (
      input  cmd_valid, cmd_on, host_valid, host_data,
`ifdef BOS_PWR_SEQ_WDT_EN
      input  pg_vcore, pg_vdig,
`endif
      output cmd_ready, host_ready, valid_bus, master_data, busy, pwr_on, fault
   );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// expire_o pulses during the last counted cycle.
module seq_timer #(
   parameter int unsigned TW = 24
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          load_i,
   input  logic [TW-1:0] value_i,
   output logic          expire_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == TW'(1));

endmodule

// File: rtl/bos_pwr_seq.sv
// Power sequencer: orders VCORE/VDIG/FUNC register writes and arbitrates host writes.
// Defining BOS_PWR_SEQ_WDT_EN adds power-good checking with a watchdog and a sticky fault.
module bos_pwr_seq
   import bos_pwr_seq_pkg::*;
#(
   parameter int unsigned DLY_VCORE = 1000,
   parameter int unsigned DLY_VDIG  = 1000,
   parameter int unsigned DLY_FUNC  = 100,
   parameter int unsigned TW        = 24
`ifdef BOS_PWR_SEQ_WDT_EN
   ,
   parameter int unsigned WDT       = 50000
`endif
) (
   input logic          clk,
   input logic          n_rst,
   bos_pwr_seq_if.slave bus
);

   localparam logic [TW-1:0] DlyVcoreW = TW'(DLY_VCORE);
   localparam logic [TW-1:0] DlyVdigW  = TW'(DLY_VDIG);
   localparam logic [TW-1:0] DlyFuncW  = TW'(DLY_FUNC);

   state_e              state_q, state_d;
   logic                cmd_up, cmd_dn;
   logic                tmr_load, tmr_expire;
   logic [TW-1:0]       tmr_val;
   logic                up_done, up_timeout, pg_drop;
   logic                seq_wr, busy;
   logic [NUM_REGS-1:0] seq_sel;
   logic [7:0]          seq_val;
   logic                host_acc, host_live;
   logic                buf_valid_q, buf_valid_d;
   logic [NUM_REGS-1:0] buf_sel_q, buf_sel_d;
   logic [7:0]          buf_data_q, buf_data_d;

   assign cmd_up = bus.cmd_valid && bus.cmd_on;
   assign cmd_dn = bus.cmd_valid && !bus.cmd_on;

`ifdef BOS_PWR_SEQ_WDT_EN
   localparam logic [TW-1:0] WdtW = TW'(WDT);
   logic wdt_q, wdt_d, fault_q, fault_d, pg_cur;

   // wdt_q marks that the delay has run out and the watchdog window is counting.
   assign pg_cur     = (state_q == StTVdig) ? bus.pg_vdig : bus.pg_vcore;
   assign up_done    = pg_cur && (tmr_expire || wdt_q);
   assign up_timeout = !pg_cur && tmr_expire && wdt_q;
   assign pg_drop    = !bus.pg_vcore || !bus.pg_vdig;

   always_comb begin
      fault_d = fault_q;
      if (state_q == StOff && cmd_up) begin
         fault_d = 1'b0;
      end else if (up_timeout || (state_q == StOn && pg_drop)) begin
         fault_d = 1'b1;
      end
      wdt_d = ((state_q == StTVcore) || (state_q == StTVdig)) && (wdt_q || tmr_expire);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wdt_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         wdt_q   <= wdt_d;
         fault_q <= fault_d;
      end
   end

   assign bus.fault = fault_q;
`else
   assign up_done    = tmr_expire;
   assign up_timeout = 1'b0;
   assign pg_drop    = 1'b0;
   assign bus.fault  = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StOff;
      end else begin
         state_q <= state_d;
      end
   end

   // An aborted power-up enters the down path at the step undoing the last write issued.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StOff:    if (cmd_up) state_d = StWVcore;
         StWVcore: begin
            if (cmd_dn) state_d = StDVcore;
            else        state_d = (DLY_VCORE == 0) ? StWVdig : StTVcore;
         end
         StTVcore: begin
            if (cmd_dn || up_timeout) state_d = StDVcore;
            else if (up_done)         state_d = StWVdig;
         end
         StWVdig: begin
            if (cmd_dn) state_d = StDVdig;
            else        state_d = (DLY_VDIG == 0) ? StWFunc : StTVdig;
         end
         StTVdig: begin
            if (cmd_dn || up_timeout) state_d = StDVdig;
            else if (up_done)         state_d = StWFunc;
         end
         StWFunc:  state_d = cmd_dn ? StDFunc : StOn;
         StOn:     if (cmd_dn || pg_drop) state_d = StDFunc;
         StDFunc:  state_d = (DLY_FUNC == 0) ? StDVdig : StTDfunc;
         StTDfunc: if (tmr_expire) state_d = StDVdig;
         StDVdig:  state_d = (DLY_FUNC == 0) ? StDVcore : StTDvdig;
         StTDvdig: if (tmr_expire) state_d = StDVcore;
         StDVcore: state_d = StOff;
         default:  state_d = StOff;
      endcase
   end

   always_comb begin
      seq_wr   = 1'b0;
      seq_sel  = '0;
      seq_val  = VAL_CLR;
      tmr_load = 1'b0;
      tmr_val  = '0;
      busy     = (state_q != StOff) && (state_q != StOn);
      unique case (state_q)
         StWVcore: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_VCORE); seq_val = VAL_CLR;
            tmr_load = 1'b1; tmr_val = DlyVcoreW;
         end
         StWVdig: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_VDIG); seq_val = VAL_CLR;
            tmr_load = 1'b1; tmr_val = DlyVdigW;
         end
         StWFunc: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_FUNC); seq_val = VAL_SET;
         end
         StDFunc: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_FUNC); seq_val = VAL_CLR;
            tmr_load = 1'b1; tmr_val = DlyFuncW;
         end
         StDVdig: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_VDIG); seq_val = VAL_SET;
            tmr_load = 1'b1; tmr_val = DlyFuncW;
         end
         StDVcore: begin
            seq_wr = 1'b1; seq_sel = reg_sel(REG_VCORE); seq_val = VAL_SET;
         end
         default: ;
      endcase
`ifdef BOS_PWR_SEQ_WDT_EN
      if ((state_q == StTVcore || state_q == StTVdig) && tmr_expire && !wdt_q) begin
         tmr_load = 1'b1;
         tmr_val  = WdtW;
      end
`endif
   end

   assign bus.cmd_ready  = 1'b1;
   assign bus.busy       = busy;
   assign bus.pwr_on     = (state_q == StOn);
   assign bus.host_ready = !buf_valid_q;

   // Rail registers are owned by the sequencer while busy; host writes to them are dropped.
   assign host_acc  = n_rst && !buf_valid_q && (bus.host_valid != '0);
   assign host_live = host_acc && !(busy && (bus.host_valid[REG_VDIG:REG_FUNC] != '0));

   always_comb begin
      buf_valid_d     = buf_valid_q;
      buf_sel_d       = buf_sel_q;
      buf_data_d      = buf_data_q;
      bus.valid_bus   = '0;
      bus.master_data = '0;
      if (seq_wr) begin
         bus.valid_bus   = seq_sel;
         bus.master_data = seq_val;
         if (host_live) begin
            buf_valid_d = 1'b1;
            buf_sel_d   = bus.host_valid;
            buf_data_d  = bus.host_data;
         end
      end else if (buf_valid_q) begin
         bus.valid_bus   = buf_sel_q;
         bus.master_data = buf_data_q;
         buf_valid_d     = 1'b0;
      end else if (host_live) begin
         bus.valid_bus   = bus.host_valid;
         bus.master_data = bus.host_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         buf_valid_q <= 1'b0;
         buf_sel_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_sel_q   <= buf_sel_d;
         buf_data_q  <= buf_data_d;
      end
   end

   seq_timer #(
      .TW(TW)
   ) u_seq_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .load_i   (tmr_load),
      .value_i  (tmr_val),
      .expire_o (tmr_expire)
   );

endmodule

// File: tb/tb_bos_pwr_seq.sv
// Directed bench for bos_pwr_seq with DLY_VCORE=4, DLY_VDIG=8, DLY_FUNC=2.
// Watchdog scenario is included when BOS_PWR_SEQ_WDT_EN is defined (WDT=10).
module tb_bos_pwr_seq;

   localparam logic [8:0] R6 = 9'h040;
   localparam logic [8:0] R7 = 9'h080;
   localparam logic [8:0] R8 = 9'h100;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   bos_pwr_seq_if bus ();

   bos_pwr_seq #(
      .DLY_VCORE (4),
      .DLY_VDIG  (8),
      .DLY_FUNC  (2),
      .TW        (24)
`ifdef BOS_PWR_SEQ_WDT_EN
      ,
      .WDT       (10)
`endif
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {valid_bus, master_data, busy, pwr_on, fault, host_ready, cmd_ready}
   function automatic logic [21:0] obs();
      return {bus.valid_bus, bus.master_data, bus.busy, bus.pwr_on, bus.fault,
              bus.host_ready, bus.cmd_ready};
   endfunction

   function automatic logic [21:0] want(input logic [8:0] vb, input logic [7:0] md,
                                        input logic bsy, input logic pwr);
      return {vb, md, bsy, pwr, 1'b0, 1'b1, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic on);
      bus.cmd_valid = 1'b1;
      bus.cmd_on    = on;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_for(input logic want_on, input string name);
      int n = 0;
      while ((want_on ? (bus.pwr_on !== 1'b1) : (bus.busy !== 1'b0)) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL %s: timed out, pwr_on=%b busy=%b required pwr_on=%b", name,
                  bus.pwr_on, bus.busy, want_on);
      end
   endtask

   task automatic test_reset();
      bus.host_valid = 9'h001;
      bus.host_data  = 8'hff;
      #1;
      checks++;
      if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL reset_state: got %h required %h", obs(), want(9'h0, 8'h00, 1'b0, 1'b0));
      end
      bus.host_valid = 9'h000;
      repeat (2) tick();
      n_rst = 1'b1;
      tick();
      checks++;
      if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL post_reset_idle: got %h required %h", obs(), want(9'h0, 8'h00, 1'b0, 1'b0));
      end
   endtask

   task automatic test_host_pass();
      bus.host_valid = 9'h001; bus.host_data = 8'ha5; #1;
      checks++;
      if (obs() !== want(9'h001, 8'ha5, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL pass_idx0: got %h required %h", obs(), want(9'h001, 8'ha5, 1'b0, 1'b0));
      end
      bus.host_valid = R7; bus.host_data = 8'h3c; #1;
      checks++;
      if (obs() !== want(R7, 8'h3c, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL pass_idx7_idle: got %h required %h", obs(), want(R7, 8'h3c, 1'b0, 1'b0));
      end
      bus.host_valid = 9'h000;
      tick();
   endtask

   task automatic test_power_up();
      logic [21:0] w;
      send_cmd(1'b1);
      for (int k = 1; k <= 16; k++) begin
         w = want((k == 1) ? R7 : (k == 6) ? R8 : (k == 15) ? R6 : 9'h0,
                  (k == 15) ? 8'h01 : 8'h00, k < 16, k == 16);
         checks++;
         if (obs() !== w) begin
            errors++;
            $display("FAIL power_up k=%0d: got %h required %h", k, obs(), w);
         end
         if (k < 16) tick();
      end
   endtask

   task automatic test_power_down(input bit poke_up, input string name);
      logic [21:0] w;
      send_cmd(1'b0);
      for (int k = 1; k <= 8; k++) begin
         w = want((k == 1) ? R6 : (k == 4) ? R8 : (k == 7) ? R7 : 9'h0,
                  (k == 4 || k == 7) ? 8'h01 : 8'h00, k < 8, 1'b0);
         checks++;
         if (obs() !== w) begin
            errors++;
            $display("FAIL %s k=%0d: got %h required %h", name, k, obs(), w);
         end
         if (poke_up && k == 2) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_on    = 1'b1;
         end
         if (k < 8) tick();
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic test_ignored_cmds();
      send_cmd(1'b0);
      checks++;
      if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL down_in_off: got %h required %h", obs(), want(9'h0, 8'h00, 1'b0, 1'b0));
      end
      test_power_up();
      send_cmd(1'b1);
      checks++;
      if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL up_in_on: got %h required %h", obs(), want(9'h0, 8'h00, 1'b0, 1'b1));
      end
   endtask

   task automatic test_abort_vcore();
      send_cmd(1'b1);
      repeat (2) tick();
      send_cmd(1'b0);
      checks++;
      if (obs() !== want(R7, 8'h01, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL abort_vcore_write: got %h required %h", obs(), want(R7, 8'h01, 1'b1, 1'b0));
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL abort_vcore_quiet k=%0d: got %h required %h", k, obs(),
                     want(9'h0, 8'h00, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_abort_vdig();
      logic [21:0] w;
      send_cmd(1'b1);
      repeat (7) tick();
      send_cmd(1'b0);
      for (int k = 1; k <= 5; k++) begin
         w = want((k == 1) ? R8 : (k == 4) ? R7 : 9'h0, (k == 1 || k == 4) ? 8'h01 : 8'h00,
                  k < 5, 1'b0);
         checks++;
         if (obs() !== w) begin
            errors++;
            $display("FAIL abort_vdig k=%0d: got %h required %h", k, obs(), w);
         end
         if (k < 5) tick();
      end
   endtask

   task automatic test_host_collision();
      send_cmd(1'b1);
      bus.host_valid = 9'h004; bus.host_data = 8'h05; #1;
      checks++;
      if ({bus.valid_bus, bus.master_data, bus.host_ready} !== {R7, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL collide_seq_wins: got %h/%h/%b required %h/00/1", bus.valid_bus,
                  bus.master_data, bus.host_ready, R7);
      end
      tick();
      bus.host_valid = 9'h000; #1;
      checks++;
      if ({bus.valid_bus, bus.master_data, bus.host_ready} !== {9'h004, 8'h05, 1'b0}) begin
         errors++;
         $display("FAIL collide_replay: got %h/%h/%b required 004/05/0", bus.valid_bus,
                  bus.master_data, bus.host_ready);
      end
      tick();
      bus.host_valid = R6; bus.host_data = 8'h01; #1;
      checks++;
      if ({bus.valid_bus, bus.host_ready} !== {9'h000, 1'b1}) begin
         errors++;
         $display("FAIL busy_idx6_drop: got %h/%b required 000/1", bus.valid_bus, bus.host_ready);
      end
      tick();
      bus.host_valid = 9'h000;
      wait_for(1'b1, "collide_reach_on");
      bus.host_valid = R6; bus.host_data = 8'h01; #1;
      checks++;
      if ({bus.valid_bus, bus.master_data} !== {R6, 8'h01}) begin
         errors++;
         $display("FAIL on_idx6_pass: got %h/%h required %h/01", bus.valid_bus, bus.master_data, R6);
      end
      bus.host_valid = 9'h000;
      tick();
      send_cmd(1'b0);
      wait_for(1'b0, "collide_reach_off");
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b1);
      repeat (8) tick();
      n_rst = 1'b0; #1;
      checks++;
      if (obs() !== want(9'h0, 8'h00, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL reset_mid: got %h required %h", obs(), want(9'h0, 8'h00, 1'b0, 1'b0));
      end
      repeat (2) tick();
      n_rst = 1'b1;
      tick();
      send_cmd(1'b1);
      checks++;
      if (obs() !== want(R7, 8'h00, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL reset_restart: got %h required %h", obs(), want(R7, 8'h00, 1'b1, 1'b0));
      end
      wait_for(1'b1, "reset_restart_on");
      send_cmd(1'b0);
      wait_for(1'b0, "reset_restart_off");
   endtask

`ifdef BOS_PWR_SEQ_WDT_EN
   task automatic test_wdt();
      bus.pg_vcore = 1'b0;
      send_cmd(1'b1);
      repeat (14) tick();
      checks++;
      if ({bus.fault, bus.busy, bus.valid_bus} !== {1'b0, 1'b1, 9'h000}) begin
         errors++;
         $display("FAIL wdt_waiting: got %b/%b/%h required 0/1/000", bus.fault, bus.busy,
                  bus.valid_bus);
      end
      tick();
      checks++;
      if ({bus.fault, bus.valid_bus, bus.master_data} !== {1'b1, R7, 8'h01}) begin
         errors++;
         $display("FAIL wdt_timeout: got %b/%h/%h required 1/%h/01", bus.fault, bus.valid_bus,
                  bus.master_data, R7);
      end
      tick();
      checks++;
      if ({bus.fault, bus.busy, bus.pwr_on} !== {1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL wdt_off: got %b/%b/%b required 1/0/0", bus.fault, bus.busy, bus.pwr_on);
      end
      bus.pg_vcore = 1'b1;
      send_cmd(1'b1);
      checks++;
      if ({bus.fault, bus.valid_bus} !== {1'b0, R7}) begin
         errors++;
         $display("FAIL wdt_fault_clear: got %b/%h required 0/%h", bus.fault, bus.valid_bus, R7);
      end
      wait_for(1'b1, "wdt_recover_on");
      send_cmd(1'b0);
      wait_for(1'b0, "wdt_recover_off");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_on     = 1'b0;
      bus.host_valid = 9'h000;
      bus.host_data  = 8'h00;
`ifdef BOS_PWR_SEQ_WDT_EN
      bus.pg_vcore   = 1'b1;
      bus.pg_vdig    = 1'b1;
`endif
      test_reset();
      test_host_pass();
      test_power_up();
      test_power_down(1'b0, "power_down");
      test_ignored_cmds();
      test_power_down(1'b1, "up_during_down");
      test_abort_vcore();
      test_abort_vdig();
      test_host_collision();
      test_reset_mid();
`ifdef BOS_PWR_SEQ_WDT_EN
      test_wdt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bos_pwr_seq.md
BOS_PWR_SEQ -- requirements
Module: bos_pwr_seq

Interface
REQ-001 Parameters: DLY_VCORE=1000 (VCORE-on to VDIG-on delay, cycles), DLY_VDIG=1000 (VDIG-on to FUNC-on delay), DLY_FUNC=100 (FUNC-off to VDIG-off and VDIG-off to VCORE-off delay), TW=24 (timer width).
REQ-002 clk  in  1  system clock; n_rst  in  1  asynchronous active-low reset.
REQ-003 cmd_valid  in  1  power command strobe; cmd_on  in  1  1=power up, 0=power down; cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-004 host_valid  in  9  one-hot host register write; host_data  in  8  host write data; host_ready  out  1  host write accepted when high.
REQ-005 valid_bus  out  9  one-hot register write to register block; master_data  out  8  write data.
REQ-006 busy  out  1  sequence in progress; pwr_on  out  1  all rails and translators up; fault  out  1  sticky sequencing fault.

Function
REQ-007 Register indices: 6=functional, 7=off_vcore (active-high off), 8=off_vdigital (active-high off); sequencer write = one-cycle one-hot valid_bus, master_data=8'h00 or 8'h01.
REQ-008 States: OFF, W_VCORE, T_VCORE, W_VDIG, T_VDIG, W_FUNC, ON, D_FUNC, T_DFUNC, D_VDIG, T_DVDIG, D_VCORE.
REQ-009 Up path: W_VCORE writes idx7=0; T_VCORE counts DLY_VCORE; W_VDIG writes idx8=0; T_VDIG counts DLY_VDIG; W_FUNC writes idx6=1; then ON.
REQ-010 Down path: D_FUNC writes idx6=0; T_DFUNC counts DLY_FUNC; D_VDIG writes idx8=1; T_DVDIG counts DLY_FUNC; D_VCORE writes idx7=1; then OFF.
REQ-011 Each W_*/D_* state lasts exactly one cycle; each T_* state lasts exactly its parameter count of cycles (count 0 = zero cycles).
REQ-012 cmd_ready=1 in all states; up command in ON or on up path ignored; down command in OFF or on down path ignored.
REQ-013 Down command during up path: enters down path at first step undoing only writes already issued (after idx7 only -> D_VCORE; after idx8 -> D_VDIG); takes effect next cycle.
REQ-014 Up command during down path: ignored until OFF reached.
REQ-015 busy=1 in every state except OFF and ON; pwr_on=1 only in ON.
REQ-016 Host arbitration: sequencer write wins; host writes to idx 6..8 while busy are dropped silently; other host writes pass through combinationally when no sequencer write occurs that cycle.
REQ-017 Collision of host write (idx 0..5) with sequencer write: host write captured in one-entry buffer, emitted next cycle; host_ready=0 while buffer full; buffered write never lost.
REQ-018 Non-busy host writes to idx 6..8 pass through unchanged.

Reset
REQ-019 n_rst low: state OFF, timer 0, buffer empty, valid_bus=0, master_data=0, busy=0, pwr_on=0, fault=0, host_ready=1.
REQ-020 Reset mid-sequence issues no writes; register block is reset to its power-off default by the same n_rst.

Configuration
REQ-021 Macro BOS_PWR_SEQ_WDT_EN defined: adds inputs pg_vcore, pg_vdig (power-good) and parameter WDT=50000.
REQ-022 With macro: each T_* up timer also requires respective pg high at expiry, else waits up to WDT cycles; timeout sets fault and forces down path per REQ-013; pg drop in ON sets fault and enters D_FUNC; fault clears on next accepted up command.
REQ-023 Without macro: timers only, fault tied 0, no pg ports.

Structure
REQ-024 Package bos_pwr_seq_pkg: state enum, register index constants (REG_FUNC=6, REG_VCORE=7, REG_VDIG=8), write-value constants.
REQ-025 One sub-module seq_timer (load, count, expire pulse, TW-bit) shared by all T_* states.

Verification (bench params DLY_VCORE=4, DLY_VDIG=8, DLY_FUNC=2)
REQ-026 Up cmd in OFF -> idx7=0 at t+1, idx8=0 at t+6, idx6=1 at t+15, pwr_on=1 at t+16.
REQ-027 Down cmd in ON -> idx6=0, idx8=1 three cycles later, idx7=1 three cycles after that, OFF, busy=0.
REQ-028 Down cmd two cycles into T_VCORE -> single write idx7=1 next cycle, no idx8/idx6 writes.
REQ-029 Host write idx2=8'h05 in same cycle as sequencer idx7 write -> idx2 write one cycle later, host_ready low that cycle; host idx6 write while busy -> dropped.
REQ-030 n_rst asserted in T_VDIG -> all outputs at reset values immediately; up cmd after release restarts from W_VCORE.
REQ-031 WDT_EN, WDT=10, pg_vcore held low -> fault=1 at T_VCORE expiry+10, idx7=1 written, state OFF.
